// File: rtl/control_unit_pkg.sv
// control_unit_pkg -- shared constants for the control unit and its decoder.
//   * ALU operation select codes (3 bits), matching the existing ALU.
//   * Instruction opcodes (instruction register bits [15:12], 4 bits).
//   * FSM state encoding (3 bits, FETCH = 000).
//   * ctrl_t: bundle of all control outputs, used to build them in one place.
package control_unit_pkg;

  // ALU operation select
  localparam logic [2:0] ALU_A     = 3'b000;
  localparam logic [2:0] ALU_NOT_A = 3'b001;
  localparam logic [2:0] ALU_ADD   = 3'b010;
  localparam logic [2:0] ALU_SUB   = 3'b011;  // a-b, or b-a with s_inm=1
  localparam logic [2:0] ALU_AND   = 3'b100;
  localparam logic [2:0] ALU_OR    = 3'b101;
  localparam logic [2:0] ALU_NEG_A = 3'b110;
  localparam logic [2:0] ALU_NEG_B = 3'b111;

  // Instruction opcodes; 0xxx is the R-type group, 1101..1111 are illegal
  localparam logic [3:0] OP_LI   = 4'b1000;
  localparam logic [3:0] OP_SUBI = 4'b1001;
  localparam logic [3:0] OP_J    = 4'b1010;
  localparam logic [3:0] OP_JZ   = 4'b1011;
  localparam logic [3:0] OP_JNZ  = 4'b1100;

  // FSM state encoding
  localparam logic [2:0] S_FETCH  = 3'b000;
  localparam logic [2:0] S_DECODE = 3'b001;
  localparam logic [2:0] S_EXEC   = 3'b010;
  localparam logic [2:0] S_WB     = 3'b011;
  localparam logic [2:0] S_HALT   = 3'b100;

  typedef struct packed {
    logic       halted;
    logic       ir_en;
    logic       pc_en;
    logic       s_inc;
    logic       we3;
    logic       wez;
    logic       s_inm;
    logic [2:0] op_alu;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{halted: 1'b0, ir_en: 1'b0, pc_en: 1'b0, s_inc: 1'b0,
                                  we3: 1'b0, wez: 1'b0, s_inm: 1'b0, op_alu: 3'b000};

  // R-type instructions are the whole 0xxx group
  function automatic logic is_rtype(input logic [3:0] op);
    return (op[3] == 1'b0);
  endfunction

endpackage

// File: rtl/control_unit_decode.sv
// cu_decode -- purely combinational instruction decoder.
//   op_i         : latched opcode (op_q of the control unit)
//   zero_i       : registered zero flag from the datapath
//   op_alu_o     : ALU operation select for EXEC/WB
//   s_inm_o      : immediate operand / reversed subtract select
//   is_alu_o     : R-type, LI or SUBI (writes the register file)
//   is_jump_o    : J, JZ or JNZ
//   is_illegal_o : 1101..1111
//   jump_taken_o : jump condition evaluated against zero_i
module cu_decode
  import control_unit_pkg::*;
(
  input  logic [3:0] op_i,
  input  logic       zero_i,
  output logic [2:0] op_alu_o,
  output logic       s_inm_o,
  output logic       is_alu_o,
  output logic       is_jump_o,
  output logic       is_illegal_o,
  output logic       jump_taken_o
);

  // Opcode to instruction class, ALU select and jump condition
  always_comb begin
    op_alu_o     = ALU_A;
    s_inm_o      = 1'b0;
    is_alu_o     = 1'b0;
    is_jump_o    = 1'b0;
    is_illegal_o = 1'b0;
    jump_taken_o = 1'b0;
    if (is_rtype(op_i)) begin
      op_alu_o = op_i[2:0];
      is_alu_o = 1'b1;
    end else begin
      case (op_i)
        OP_LI: begin
          op_alu_o = ALU_NEG_B;
          s_inm_o  = 1'b1;
          is_alu_o = 1'b1;
        end
        OP_SUBI: begin
          op_alu_o = ALU_SUB;
          s_inm_o  = 1'b1;
          is_alu_o = 1'b1;
        end
        OP_J: begin
          is_jump_o    = 1'b1;
          jump_taken_o = 1'b1;
        end
        OP_JZ: begin
          is_jump_o    = 1'b1;
          jump_taken_o = zero_i;
        end
        OP_JNZ: begin
          is_jump_o    = 1'b1;
          jump_taken_o = ~zero_i;
        end
        default: begin
          is_illegal_o = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/control_unit.sv
// control_unit -- multi-cycle sequencer: FETCH -> DECODE -> EXEC [-> WB] -> FETCH,
// with HALT on an illegal opcode (left only through reset).
//   clk       : clock, all state on rising edge
//   reset     : synchronous, active-low
//   mem_ready : instruction word at PC is valid (FETCH waits for it)
//   opcode    : IR[15:12], latched into op_q during DECODE
//   zero      : registered zero flag, used only in EXEC of JZ/JNZ
//   op_alu    : ALU operation select (EXEC and WB only)
//   s_inm     : immediate / reversed subtract select (EXEC and WB only)
//   ir_en, pc_en, s_inc, we3, wez : datapath enables
//   halted    : sequencer stopped
// Outputs are decoded from the current state (and mem_ready/zero where the
// FETCH handshake and jump condition need them) and forced to 0 while reset
// is low, so an instruction interrupted by reset never writes.
module control_unit
  import control_unit_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       mem_ready,
  input  logic [3:0] opcode,
  input  logic       zero,
  output logic [2:0] op_alu,
  output logic       s_inm,
  output logic       ir_en,
  output logic       pc_en,
  output logic       s_inc,
  output logic       we3,
  output logic       wez,
  output logic       halted
);

  logic [2:0] state_q, state_d;
  logic [3:0] op_q, op_d;
  ctrl_t      ctrl_s;

  logic [2:0] dec_op_alu_s;
  logic       dec_s_inm_s;
  logic       dec_is_alu_s;
  logic       dec_is_jump_s;
  logic       dec_is_illegal_s;
  logic       dec_taken_s;

  cu_decode u_decode (
    .op_i         (op_q),
    .zero_i       (zero),
    .op_alu_o     (dec_op_alu_s),
    .s_inm_o      (dec_s_inm_s),
    .is_alu_o     (dec_is_alu_s),
    .is_jump_o    (dec_is_jump_s),
    .is_illegal_o (dec_is_illegal_s),
    .jump_taken_o (dec_taken_s)
  );

  // Next-state and opcode latch logic
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        op_d    = opcode;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (dec_is_alu_s) begin
          state_d = S_WB;
        end else if (dec_is_illegal_s) begin
          state_d = S_HALT;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_WB: begin
        state_d = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        // Unused encodings recover to FETCH
        state_d = S_FETCH;
      end
    endcase
  end

  // State and opcode registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_FETCH;
      op_q    <= 4'b0000;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Output decode; everything is held at 0 while reset is low
  always_comb begin
    ctrl_s = CTRL_IDLE;
    if (!reset) begin
      ctrl_s = CTRL_IDLE;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (mem_ready) begin
            ctrl_s.ir_en = 1'b1;
            ctrl_s.pc_en = 1'b1;
            ctrl_s.s_inc = 1'b1;
          end else begin
            ctrl_s = CTRL_IDLE;
          end
        end
        S_EXEC: begin
          if (dec_is_alu_s) begin
            ctrl_s.op_alu = dec_op_alu_s;
            ctrl_s.s_inm  = dec_s_inm_s;
            ctrl_s.wez    = 1'b1;
          end else if (dec_is_jump_s && dec_taken_s) begin
            // Taken jump loads the target; s_inc stays 0
            ctrl_s.pc_en = 1'b1;
          end else begin
            ctrl_s = CTRL_IDLE;
          end
        end
        S_WB: begin
          // op_q is unchanged since EXEC, so the decoder still holds the ALU select
          ctrl_s.op_alu = dec_op_alu_s;
          ctrl_s.s_inm  = dec_s_inm_s;
          ctrl_s.we3    = 1'b1;
        end
        S_HALT: begin
          ctrl_s.halted = 1'b1;
        end
        default: begin
          ctrl_s = CTRL_IDLE;
        end
      endcase
    end
  end

  assign op_alu = ctrl_s.op_alu;
  assign s_inm  = ctrl_s.s_inm;
  assign ir_en  = ctrl_s.ir_en;
  assign pc_en  = ctrl_s.pc_en;
  assign s_inc  = ctrl_s.s_inc;
  assign we3    = ctrl_s.we3;
  assign wez    = ctrl_s.wez;
  assign halted = ctrl_s.halted;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit -- self-checking bench for control_unit.
// Expected outputs come from an instruction-level model: each instruction is a
// list of cycles (wait cycles, fetch, decode, execute, optional write-back or
// halt) whose outputs follow from the opcode and the zero flag.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       mem_ready;
  logic [3:0] opcode;
  logic       zero;
  logic [2:0] op_alu;
  logic       s_inm;
  logic       ir_en;
  logic       pc_en;
  logic       s_inc;
  logic       we3;
  logic       wez;
  logic       halted;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  control_unit dut (
    .clk       (clk),
    .reset     (reset),
    .mem_ready (mem_ready),
    .opcode    (opcode),
    .zero      (zero),
    .op_alu    (op_alu),
    .s_inm     (s_inm),
    .ir_en     (ir_en),
    .pc_en     (pc_en),
    .s_inc     (s_inc),
    .we3       (we3),
    .wez       (wez),
    .halted    (halted)
  );

  // Output vector layout: {halted, ir_en, pc_en, s_inc, we3, wez, s_inm, op_alu[2:0]}
  function automatic logic [9:0] ev(input logic h, input logic ir, input logic pc,
                                    input logic si, input logic w3, input logic wz,
                                    input logic sm, input logic [2:0] alu);
    return {h, ir, pc, si, w3, wz, sm, alu};
  endfunction

  localparam logic [9:0] V_IDLE  = 10'b00_0000_0000;
  localparam logic [9:0] V_FETCH = 10'b01_1100_0000;
  localparam logic [9:0] V_HALT  = 10'b10_0000_0000;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [9:0] exp);
    logic [9:0] obs;
    @(negedge clk);
    obs = {halted, ir_en, pc_en, s_inc, we3, wez, s_inm, op_alu};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_opq(input string tag, input logic [3:0] exp);
    vectors++;
    assert (dut.op_q === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, dut.op_q, exp);
    end
  endtask

  // Hold reset low for n cycles (mem_ready high to show it is ignored)
  task automatic do_reset(input int n, input string tag);
    reset     = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      chk({tag, "/in_reset"}, V_IDLE);
      step();
    end
    reset = 1'b1;
    chk_opq({tag, "/op_q"}, 4'b0000);
  endtask

  // Execute-cycle outputs from the instruction set rules; cls 0=ALU 1=jump 2=illegal
  task automatic exec_model(input logic [3:0] opc, input logic zr,
                            output logic [9:0] e, output logic [9:0] wb, output int cls);
    int o;
    o   = int'(opc);
    wb  = V_IDLE;
    cls = 1;
    if (o < 8) begin
      e  = ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, opc[2:0]);
      wb = ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, opc[2:0]);
      cls = 0;
    end else if (o == 8) begin
      e  = ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b111);
      wb = ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'b111);
      cls = 0;
    end else if (o == 9) begin
      e  = ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b011);
      wb = ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'b011);
      cls = 0;
    end else if (o == 10 || (o == 11 && zr) || (o == 12 && !zr)) begin
      e = ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    end else if (o == 11 || o == 12) begin
      e = V_IDLE;
    end else begin
      e   = V_IDLE;
      cls = 2;
    end
  endtask

  // One complete instruction, checked cycle by cycle
  task automatic run_instr(input logic [3:0] opc, input int waits, input logic zr,
                           input string tag, input int halt_cycles);
    logic [9:0] e_exec;
    logic [9:0] e_wb;
    int         cls;
    for (int w = 0; w < waits; w++) begin
      mem_ready = 1'b0;
      opcode    = 4'($urandom);
      zero      = 1'($urandom);
      chk({tag, "/wait"}, V_IDLE);
      step();
    end
    mem_ready = 1'b1;
    opcode    = opc;
    chk({tag, "/fetch"}, V_FETCH);
    step();
    mem_ready = 1'($urandom);
    chk({tag, "/decode"}, V_IDLE);
    step();
    // Opcode bus changes after decode; the latched copy must be used
    opcode    = ~opc;
    mem_ready = 1'($urandom);
    zero      = zr;
    exec_model(opc, zr, e_exec, e_wb, cls);
    chk({tag, "/exec"}, e_exec);
    step();
    if (cls == 0) begin
      zero      = 1'($urandom);
      mem_ready = 1'($urandom);
      chk({tag, "/wb"}, e_wb);
      step();
    end else if (cls == 2) begin
      for (int h = 0; h < halt_cycles; h++) begin
        mem_ready = ~mem_ready;
        zero      = 1'($urandom);
        chk({tag, "/halt"}, V_HALT);
        step();
      end
    end
  endtask

  initial begin
    reset     = 1'b0;
    mem_ready = 1'b1;
    opcode    = 4'b0000;
    zero      = 1'b0;
    step();
    do_reset(2, "reset2");

    // Directed scenarios
    run_instr(4'b0010, 0, 1'b0, "add", 0);
    run_instr(4'b1001, 3, 1'b1, "subi_wait3", 0);
    run_instr(4'b1011, 0, 1'b1, "jz_taken", 0);
    run_instr(4'b1011, 0, 1'b0, "jz_not", 0);
    run_instr(4'b1100, 0, 1'b0, "jnz_taken", 0);
    run_instr(4'b1100, 0, 1'b1, "jnz_not", 0);
    run_instr(4'b1010, 0, 1'($urandom), "j", 0);
    run_instr(4'b1000, 1, 1'b0, "li", 0);
    run_instr(4'b1110, 0, 1'b0, "illegal", 10);
    do_reset(1, "halt_exit");
    run_instr(4'b0101, 0, 1'b0, "after_halt", 0);

    // Reset during EXEC of opcode 0101 abandons it without a write
    mem_ready = 1'b1;
    opcode    = 4'b0101;
    chk("midrst/fetch", V_FETCH);
    step();
    chk("midrst/decode", V_IDLE);
    step();
    reset = 1'b0;
    chk("midrst/exec", V_IDLE);
    step();
    reset     = 1'b1;
    mem_ready = 1'b0;
    chk_opq("midrst/op_q", 4'b0000);
    chk("midrst/next", V_IDLE);
    step();

    // Randomized legal instruction stream
    for (int k = 0; k < 60; k++) begin
      run_instr(4'($urandom_range(0, 12)), int'($urandom_range(0, 2)), 1'($urandom), "rnd", 0);
    end

    // Random illegal opcodes, each followed by reset
    for (int k = 0; k < 3; k++) begin
      run_instr(4'($urandom_range(13, 15)), 0, 1'($urandom), "rnd_illegal", 3);
      do_reset(1, "rnd_illegal_exit");
    end
    run_instr(4'($urandom_range(0, 12)), 0, 1'($urandom), "final", 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have a single clock `clk`, and all state SHALL update on its rising edge.
REQ-002 Reset SHALL be `reset`: input, 1 bit, synchronous and active-low; it is sampled only on the rising edge of `clk`.
REQ-003 Port `mem_ready` SHALL be an input, 1 bit: the instruction memory word at the current PC is valid this cycle.
REQ-004 Port `opcode` SHALL be an input, 4 bits: the instruction register bits [15:12], stable from the cycle after an IR load.
REQ-005 Port `zero` SHALL be an input, 1 bit: the output of the datapath's registered zero-flag.
REQ-006 Port `op_alu` SHALL be an output, 3 bits: the ALU operation select, with the existing ALU encoding (000 a, 001 ~a, 010 a+b, 011 a-b or b-a, 100 and, 101 or, 110 -a, 111 -b).
REQ-007 Port `s_inm` SHALL be an output, 1 bit: selects the immediate operand and the reversed subtract in the ALU.
REQ-008 The following outputs SHALL each be 1 bit:
- `ir_en`: instruction register load.
- `pc_en`: PC load.
- `s_inc`: PC source, 1 = PC+1, 0 = jump target.
- `we3`: register file write.
- `wez`: zero-flag register load.
- `halted`: the sequencer is stopped.

Function
REQ-009 The FSM SHALL have exactly these states: FETCH, DECODE, EXEC, WB, HALT.
REQ-010 In FETCH:
- With `mem_ready`=1: assert `ir_en`=1, `pc_en`=1, `s_inc`=1, then go to DECODE.
- With `mem_ready`=0: all enables 0 and stay in FETCH, with no limit on wait cycles.
REQ-011 In DECODE, the block SHALL latch `opcode` into internal register op_q, assert no enables, and go to EXEC.
REQ-012 Decode of op_q SHALL be:
- 0ooo: R-type, op_alu=ooo, s_inm=0.
- 1000: LI, op_alu=111, s_inm=1.
- 1001: SUBI, op_alu=011, s_inm=1.
- 1010: J.
- 1011: JZ.
- 1100: JNZ.
- 1101 to 1111: illegal.
REQ-013 In EXEC for R-type, LI or SUBI, the block SHALL drive the decoded op_alu and s_inm, assert `wez`=1, and go to WB.
REQ-014 In WB, the block SHALL hold op_alu and s_inm from EXEC, assert `we3`=1 and `wez`=0, and go to FETCH.
REQ-015 In EXEC for jumps, the block SHALL assert `pc_en`=1 and `s_inc`=0 when the jump is taken, assert no enables when it is not, and go to FETCH.
- J: always taken.
- JZ: taken when `zero`=1.
- JNZ: taken when `zero`=0.
REQ-016 In EXEC for an illegal opcode, the block SHALL assert no enables and go to HALT.
REQ-017 HALT SHALL assert `halted`=1 and all enables 0, and SHALL remain in HALT until reset.
REQ-018 In any state where an enable is not explicitly asserted, that enable SHALL be 0; op_alu SHALL be 000 and s_inm 0 outside EXEC and WB.
REQ-019 Latency, counted from the first FETCH cycle with `mem_ready`=1:
- ALU-class instructions: 4 cycles.
- Jumps: 3 cycles.
- Each wait cycle with `mem_ready`=0 adds 1 cycle.
REQ-020 Only one of `pc_en` (jump), `we3` or `ir_en` SHALL be asserted per cycle; `wez` and `we3` SHALL never be high together.
REQ-021 `zero` SHALL be sampled only in EXEC of a conditional jump; a `wez` in the preceding instruction's EXEC is therefore visible to it.

Reset
REQ-022 With `reset`=0 at a rising edge, the next state SHALL be FETCH, op_q SHALL be 0000, and all outputs SHALL be 0 (including `halted`), regardless of current state.
REQ-023 While `reset`=0, the block SHALL assert no enables; a reset asserted mid-instruction (DECODE, EXEC, WB) SHALL abandon that instruction with no write.
REQ-024 Reset SHALL be the only exit from HALT.

Structure
REQ-025 A shared package SHALL hold:
- the ALU op codes (3 bits);
- the instruction opcodes (4 bits);
- the FSM state encoding (3 bits, FETCH=000).
REQ-026 A combinational sub-module `cu_decode` SHALL map op_q to op_alu, s_inm, an is_alu/is_jump/is_illegal class and the jump condition; control_unit SHALL hold the FSM and op_q.

Verification
REQ-027 A bench SHALL cover these directed scenarios:
- Reset low for 2 cycles, then `mem_ready`=1, `opcode`=0010: required cycle sequence is FETCH (ir_en, pc_en, s_inc) -> DECODE -> EXEC (op_alu=010, wez=1) -> WB (we3=1, op_alu=010) -> FETCH.
- `opcode`=1001, with `mem_ready`=0 for 3 cycles then 1: FETCH holds for 3 cycles with all enables 0, then EXEC shows op_alu=011, s_inm=1; total 7 cycles.
- `opcode`=1011 with `zero`=1: EXEC shows pc_en=1, s_inc=0. Repeat with `zero`=0: EXEC shows pc_en=0; both return to FETCH after 3 cycles.
- `opcode`=1100 with `zero`=0: taken. `opcode`=1010: always taken, pc_en=1, s_inc=0.
- `opcode`=1110: HALT with halted=1. `mem_ready` toggled for 10 cycles leaves all outputs stuck. Reset low for 1 cycle returns to FETCH with halted=0.
- `reset` driven low in the EXEC cycle of opcode 0101: the next cycle is FETCH with we3 never asserted and op_q=0000.
